// File: rtl/dc_ipu_array_divider_iter.sv
// rtl/dc_ipu_array_divider_iter.sv - iterative restoring unsigned divider, STAGES_PER_CYCLE bits per clock
module dc_ipu_array_divider_iter #(
    parameter int A_WIDTH          = 16,
    parameter int B_WIDTH          = 8,
    parameter int STAGES_PER_CYCLE = 1,
    parameter int TAG_WIDTH        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_WIDTH-1:0]   out_q,
    output logic [B_WIDTH-1:0]   out_r,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_dbz
);

    localparam int ITER  = (A_WIDTH + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [A_WIDTH-1:0]   a_q, a_d;
    logic [B_WIDTH-1:0]   b_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [B_WIDTH:0]     rem_q, rem_d;
    logic [A_WIDTH-1:0]   quo_q, quo_d;
    logic                 out_valid_q;
    logic [A_WIDTH-1:0]   out_q_q;
    logic [B_WIDTH-1:0]   out_r_q;
    logic [TAG_WIDTH-1:0] out_tag_q;
    logic                 out_dbz_q;

    logic [B_WIDTH:0]     rem_sh;
    logic [B_WIDTH+1:0]   diff;
    logic                 accept;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
    assign out_r     = out_r_q;
    assign out_tag   = out_tag_q;
    assign out_dbz   = out_dbz_q;

    // One clock's worth of restoring stages; stages past the last dividend bit are skipped.
    always_comb begin
        a_d    = a_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        rem_sh = '0;
        diff   = '0;
        for (int s = 0; s < STAGES_PER_CYCLE; s++) begin
            if (int'(cnt_q) * STAGES_PER_CYCLE + s < A_WIDTH) begin
                rem_sh = {rem_d[B_WIDTH-1:0], a_d[A_WIDTH-1]};
                diff   = {1'b0, rem_sh} - {2'b00, b_q};
                a_d    = a_d << 1;
                quo_d  = quo_d << 1;
                if (diff[B_WIDTH+1]) begin
                    rem_d = rem_sh;
                end else begin
                    rem_d    = diff[B_WIDTH:0];
                    quo_d[0] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
            out_r_q     <= '0;
            out_tag_q   <= '0;
            out_dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        tag_q   <= in_tag;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    a_q   <= a_d;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        // b == 0 falls out naturally: every stage sets its quotient bit and the
                        // remainder ends up holding the low dividend bits.
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_q_q     <= quo_d;
                        out_r_q     <= rem_d[B_WIDTH-1:0];
                        out_tag_q   <= tag_q;
                        out_dbz_q   <= (b_q == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            a_q     <= in_a;
                            b_q     <= in_b;
                            tag_q   <= in_tag;
                            rem_q   <= '0;
                            quo_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= BUSY;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dc_ipu_array_divider_iter.sv
// tb/tb_dc_ipu_array_divider_iter.sv - scoreboard bench over three divider configurations
module tb_dc_ipu_array_divider_iter;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic [3:0]  tag;
        logic        dbz;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic        iv[3];
    logic        ordy[3];
    logic [15:0] ia[3];
    logic [7:0]  ib[3];
    logic [3:0]  it[3];

    logic        ir[3];
    logic        ov[3];
    logic        odbz[3];
    logic [15:0] oq[3];
    logic [7:0]  orr[3];
    logic [3:0]  otag[3];

    logic        w_ir0, w_ov0, w_dbz0, w_ir1, w_ov1, w_dbz1, w_ir2, w_ov2, w_dbz2;
    logic [15:0] w_q0, w_q1;
    logic [9:0]  w_q2;
    logic [7:0]  w_r0, w_r1;
    logic [3:0]  w_r2;
    logic [3:0]  w_tag0, w_tag1, w_tag2;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];
    exp_t mon_e;
    bit   mon_ok;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dc_ipu_array_divider_iter #(.A_WIDTH(16), .B_WIDTH(8), .STAGES_PER_CYCLE(1), .TAG_WIDTH(4)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(w_ir0), .in_a(ia[0]), .in_b(ib[0]),
        .in_tag(it[0]), .out_valid(w_ov0), .out_ready(ordy[0]), .out_q(w_q0), .out_r(w_r0),
        .out_tag(w_tag0), .out_dbz(w_dbz0));

    dc_ipu_array_divider_iter #(.A_WIDTH(16), .B_WIDTH(8), .STAGES_PER_CYCLE(4), .TAG_WIDTH(4)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(w_ir1), .in_a(ia[1]), .in_b(ib[1]),
        .in_tag(it[1]), .out_valid(w_ov1), .out_ready(ordy[1]), .out_q(w_q1), .out_r(w_r1),
        .out_tag(w_tag1), .out_dbz(w_dbz1));

    dc_ipu_array_divider_iter #(.A_WIDTH(10), .B_WIDTH(4), .STAGES_PER_CYCLE(4), .TAG_WIDTH(4)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(w_ir2), .in_a(ia[2][9:0]), .in_b(ib[2][3:0]),
        .in_tag(it[2]), .out_valid(w_ov2), .out_ready(ordy[2]), .out_q(w_q2), .out_r(w_r2),
        .out_tag(w_tag2), .out_dbz(w_dbz2));

    always_comb begin
        ir[0] = w_ir0;  ov[0] = w_ov0;  oq[0] = w_q0;           orr[0] = w_r0;          otag[0] = w_tag0;  odbz[0] = w_dbz0;
        ir[1] = w_ir1;  ov[1] = w_ov1;  oq[1] = w_q1;           orr[1] = w_r1;          otag[1] = w_tag1;  odbz[1] = w_dbz1;
        ir[2] = w_ir2;  ov[2] = w_ov2;  oq[2] = {6'd0, w_q2};   orr[2] = {4'd0, w_r2};  otag[2] = w_tag2;  odbz[2] = w_dbz2;
    end

    function automatic int aw_of(int d);
        return (d == 2) ? 10 : 16;
    endfunction

    function automatic int bw_of(int d);
        return (d == 2) ? 4 : 8;
    endfunction

    function automatic int iter_of(int d);
        case (d)
            0:       return 16;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic exp_t model(int d, logic [15:0] a, logic [7:0] b, logic [3:0] tag);
        exp_t e;
        int   ai, bi;
        ai = int'(a);
        bi = int'(b);
        e.tag = tag;
        if (bi == 0) begin
            e.q   = 16'((1 << aw_of(d)) - 1);
            e.r   = 8'(ai & ((1 << bw_of(d)) - 1));
            e.dbz = 1'b1;
        end else begin
            e.q   = 16'(ai / bi);
            e.r   = 8'(ai % bi);
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic push_exp(int d, exp_t e);
        case (d)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(int d, output exp_t e, output bit ok);
        e  = '0;
        ok = 1'b1;
        case (d)
            0:       if (sb0.size() > 0) e = sb0.pop_front(); else ok = 1'b0;
            1:       if (sb1.size() > 0) e = sb1.pop_front(); else ok = 1'b0;
            default: if (sb2.size() > 0) e = sb2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // Every completed handoff is matched against the oldest expected result of that divider.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && ordy[d]) begin
                    pop_exp(d, mon_e, mon_ok);
                    n_checks++;
                    if (!mon_ok) begin
                        n_fail++;
                        $display("FAIL result_unexpected dut%0d: got q=%h r=%h tag=%h with no pending operation",
                                 d, oq[d], orr[d], otag[d]);
                    end else if (oq[d] !== mon_e.q || orr[d] !== mon_e.r || otag[d] !== mon_e.tag || odbz[d] !== mon_e.dbz) begin
                        n_fail++;
                        $display("FAIL result dut%0d: got q=%h r=%h tag=%h dbz=%b, expected q=%h r=%h tag=%h dbz=%b",
                                 d, oq[d], orr[d], otag[d], odbz[d], mon_e.q, mon_e.r, mon_e.tag, mon_e.dbz);
                    end
                end
            end
        end
    end

    // Called just after the accept edge; returns at the negedge on which out_valid is first seen.
    task automatic wait_result(int d, string nm);
        int n;
        bit seen;
        bit rdy_hi;
        n      = 0;
        seen   = 1'b0;
        rdy_hi = 1'b0;
        while (n < 200 && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ov[d]) seen = 1'b1;
            else if (ir[d]) rdy_hi = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: out_valid not seen within %0d cycles", nm, n);
        end else if (n != iter_of(d)) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, expected %0d", nm, n, iter_of(d));
        end
        n_checks++;
        if (rdy_hi) begin
            n_fail++;
            $display("FAIL %s_busy_ready: in_ready got 1 while busy, expected 0", nm);
        end
    endtask

    task automatic run(int d, logic [15:0] a, logic [7:0] b, logic [3:0] tag, string nm);
        bit acc;
        @(posedge clk);
        #1;
        iv[d] = 1'b1; ia[d] = a; ib[d] = b; it[d] = tag;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (ir[d]) acc = 1'b1;
        end
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL %s_accept: in_ready got 0 for 50 cycles, expected 1", nm);
            iv[d] = 1'b0;
        end else begin
            push_exp(d, model(d, a, b, tag));
            @(posedge clk);
            #1;
            iv[d] = 1'b0;
            wait_result(d, nm);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (ov[d] !== 1'b0 || oq[d] !== 16'd0 || orr[d] !== 8'd0 || otag[d] !== 4'd0 || odbz[d] !== 1'b0 || ir[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got valid=%b q=%h r=%h tag=%h dbz=%b ready=%b, expected 0 0 0 0 0 1",
                         d, ov[d], oq[d], orr[d], otag[d], odbz[d], ir[d]);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b valid=%b, expected 1 0", ir[0], ov[0]);
        end
    endtask

    task automatic test_spc1;
        run(0, 16'd1000, 8'd7, 4'd3, "spc1_1000_7");
        run(0, 16'd65535, 8'd1, 4'd5, "spc1_max_1");
    endtask

    task automatic test_spc4;
        run(1, 16'hFFFF, 8'hFF, 4'd1, "spc4_ffff_ff");
        run(1, 16'd5, 8'd9, 4'd2, "spc4_5_9");
    endtask

    task automatic test_partial;
        run(2, 16'd1023, 8'd10, 4'd5, "part_1023_10");
        run(2, 16'd0, 8'd1, 4'd6, "part_0_1");
        run(2, 16'd700, 8'd0, 4'd8, "part_dbz");
    endtask

    task automatic test_dbz;
        run(0, 16'h1234, 8'd0, 4'd9, "dbz_1234");
    endtask

    task automatic test_back_to_back;
        @(posedge clk);
        #1 ordy[0] = 1'b0;
        run(0, 16'd77, 8'd4, 4'd2, "bp_77_4");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (ov[0] !== 1'b1 || oq[0] !== 16'd19 || orr[0] !== 8'd1 || otag[0] !== 4'd2 || ir[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle%0d: got valid=%b q=%h r=%h tag=%h ready=%b, expected 1 0013 01 2 0",
                         i, ov[0], oq[0], orr[0], otag[0], ir[0]);
            end
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        iv[0] = 1'b1; ia[0] = 16'd100; ib[0] = 8'd3; it[0] = 4'd4;
        @(negedge clk);
        n_checks++;
        if (ir[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got in_ready=%b, expected 1", ir[0]);
        end
        push_exp(0, model(0, 16'd100, 8'd3, 4'd4));
        @(posedge clk);
        #1 iv[0] = 1'b0;
        wait_result(0, "b2b_100_3");
    endtask

    task automatic test_reset_mid;
        bit seen;
        @(posedge clk);
        #1;
        iv[0] = 1'b1; ia[0] = 16'd200; ib[0] = 8'd3; it[0] = 4'd1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ov[0] !== 1'b0 || oq[0] !== 16'd0 || orr[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_clear: got valid=%b q=%h r=%h, expected 0 0000 00", ov[0], oq[0], orr[0]);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_release: got ready=%b valid=%b, expected 1 0", ir[0], ov[0]);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL midreset_stale: got out_valid=1 after abandoned op, expected 0");
        end
        run(0, 16'd50, 8'd5, 4'd7, "post_reset_50_5");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; ia[d] = '0; ib[d] = '0; it[d] = '0;
        end
        test_reset;
        test_spc1;
        test_spc4;
        test_partial;
        test_dbz;
        test_back_to_back;
        test_reset_mid;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb0.size() + sb1.size() + sb2.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sb0.size() + sb1.size() + sb2.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
